// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, byte-enabled write and sweep-clear signals of regfile_mp.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]   rd_addr_a, rd_addr_b, wr_addr;
    logic [DATA_W-1:0]   rd_data_a, rd_data_b, wr_data;
    logic [DATA_W/8-1:0] wr_be;
    logic                we_, clr, busy;
    modport master (
        output rd_addr_a, rd_addr_b, we_, wr_addr, wr_be, wr_data, clr,
        input  rd_data_a, rd_data_b, busy
    );
    modport slave (
        input  rd_addr_a, rd_addr_b, we_, wr_addr, wr_be, wr_data, clr,
        output rd_data_a, rd_data_b, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: byte-enabled register file, two combinational read ports, DEPTH-cycle sweep clear.
// Define REGFILE_MP_BYPASS_EN to forward an accepted write to matching read ports in the same cycle.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] be_mask;
    logic              busy, wr_ok;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, wd, mask);
        return (old & ~mask) | (wd & mask);
    endfunction

    assign busy     = state == CLEAR;
    assign bus.busy = busy;
    assign wr_ok    = !bus.we_ && !busy && ({1'b0, bus.wr_addr} < DEPTH_L) && |bus.wr_be;

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < NB; b++) be_mask[8*b +: 8] = {8{bus.wr_be[b]}};
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (state == IDLE) begin
            state_nx = bus.clr ? CLEAR : IDLE;
            ptr_nx   = '0;
        end else begin
            state_nx = (ptr == LAST) ? IDLE : CLEAR;
            ptr_nx   = (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end

    // The sweep owns the array while busy; incoming writes are simply dropped.
    always_ff @(posedge clk or posedge reset)
        if (reset)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else
            for (int i = 0; i < DEPTH; i++)
                if (busy && ptr == ADDR_W'(i)) mem[i] <= '0;
                else if (wr_ok && bus.wr_addr == ADDR_W'(i)) mem[i] <= merge(mem[i], bus.wr_data, be_mask);

    always_comb begin
        bus.rd_data_a = '0;
        bus.rd_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_addr_a == ADDR_W'(i)) bus.rd_data_a = mem[i];
            if (bus.rd_addr_b == ADDR_W'(i)) bus.rd_data_b = mem[i];
        end
`ifdef REGFILE_MP_BYPASS_EN
        if (wr_ok && bus.rd_addr_a == bus.wr_addr) bus.rd_data_a = merge(bus.rd_data_a, bus.wr_data, be_mask);
        if (wr_ok && bus.rd_addr_b == bus.wr_addr) bus.rd_data_b = merge(bus.rd_data_b, bus.wr_data, be_mask);
`endif
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus hand-written sweep, bypass and reset sequences.
// ADDR_W is 6 so that addresses beyond DEPTH (40, 63) can be driven.
module tb_regfile_mp;
    logic clk = 0;
    logic reset = 1;
    int   errors = 0;
    int   checks = 0;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(6)) bus ();
    regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        we_n;
        logic [5:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [5:0]  ra, rb;
        logic [31:0] ea, eb;
    } vec_t;

    vec_t v [9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.we_ = 0; bus.wr_addr = a; bus.wr_be = be; bus.wr_data = d;
        tick();
        bus.we_ = 1;
    endtask

    initial begin
        int busy_cnt, nz;
        v[0] = '{0, 6'd3,  4'hF, 32'hDEADBEEF, 6'd3,  6'd3,  32'hDEADBEEF, 32'hDEADBEEF};
        v[1] = '{0, 6'd3,  4'h3, 32'h00001122, 6'd3,  6'd3,  32'hDEAD1122, 32'hDEAD1122};
        v[2] = '{0, 6'd3,  4'h0, 32'hAABBCCDD, 6'd3,  6'd0,  32'hDEAD1122, 32'h00000000};
        v[3] = '{1, 6'd3,  4'hF, 32'h00000000, 6'd3,  6'd3,  32'hDEAD1122, 32'hDEAD1122};
        v[4] = '{0, 6'd40, 4'hF, 32'hFFFFFFFF, 6'd40, 6'd3,  32'h00000000, 32'hDEAD1122};
        v[5] = '{0, 6'd31, 4'hA, 32'h55AA55AA, 6'd31, 6'd0,  32'h55005500, 32'h00000000};
        v[6] = '{0, 6'd0,  4'hF, 32'hCAFEF00D, 6'd0,  6'd31, 32'hCAFEF00D, 32'h55005500};
        v[7] = '{0, 6'd63, 4'hF, 32'h77777777, 6'd63, 6'd0,  32'h00000000, 32'hCAFEF00D};
        v[8] = '{0, 6'd31, 4'h4, 32'h11223344, 6'd31, 6'd31, 32'h55225500, 32'h55225500};

        bus.we_ = 1; bus.clr = 0; bus.wr_addr = 0; bus.wr_be = 0; bus.wr_data = 0;
        bus.rd_addr_a = 0; bus.rd_addr_b = 31;
        #3;
        chk("reset_busy", {31'b0, bus.busy}, 0);
        chk("reset_rd_a0", bus.rd_data_a, 0);
        chk("reset_rd_b31", bus.rd_data_b, 0);
        tick();
        reset = 0;
        tick();
        chk("idle_after_reset", {31'b0, bus.busy}, 0);

        for (int k = 0; k < 9; k++) begin
            bus.we_ = v[k].we_n; bus.wr_addr = v[k].wa; bus.wr_be = v[k].be; bus.wr_data = v[k].wd;
            bus.rd_addr_a = v[k].ra; bus.rd_addr_b = v[k].rb;
            tick();
            bus.we_ = 1;
            #1;
            chk($sformatf("vec%0d_a", k), bus.rd_data_a, v[k].ea);
            chk($sformatf("vec%0d_b", k), bus.rd_data_b, v[k].eb);
        end

        // Same-cycle visibility of a write depends on forwarding.
        bus.rd_addr_a = 0; bus.rd_addr_b = 7;
        bus.we_ = 0; bus.wr_addr = 7; bus.wr_be = 4'hF; bus.wr_data = 32'h12345678;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        chk("bypass_same_cycle", bus.rd_data_b, 32'h12345678);
`else
        chk("nobypass_same_cycle", bus.rd_data_b, 32'h00000000);
`endif
        tick();
        bus.we_ = 1;
        chk("write7_next_cycle", bus.rd_data_b, 32'h12345678);

        // Sweep: clr with a simultaneous write to 5, drop a write at cycle 10, ignore a second clr.
        bus.clr = 1;
        write(6'd5, 4'hF, 32'hFFFFFFFF);
        bus.clr = 0;
        bus.rd_addr_a = 5;
        #1;
        chk("clr_edge_write", bus.rd_data_a, 32'hFFFFFFFF);
        chk("busy_first", {31'b0, bus.busy}, 1);
        busy_cnt = bus.busy ? 1 : 0;
        bus.rd_addr_a = 3; bus.rd_addr_b = 7;
        for (int c = 1; c < 40; c++) begin
            if (c == 11) begin
                bus.we_ = 0; bus.wr_addr = 5; bus.wr_be = 4'hF; bus.wr_data = 32'h0BAD0BAD;
            end
            if (c == 21) bus.clr = 1;
            tick();
            bus.we_ = 1; bus.clr = 0;
            if (bus.busy) busy_cnt++;
            if (c == 4) begin
                chk("sweep_swept_3", bus.rd_data_a, 0);
                chk("sweep_unswept_7", bus.rd_data_b, 32'h12345678);
            end
        end
        chk("busy_cycles", busy_cnt, 32);
        chk("busy_end", {31'b0, bus.busy}, 0);
        nz = 0;
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr_a = a[5:0]; bus.rd_addr_b = a[5:0];
            #1;
            if (bus.rd_data_a != 0 || bus.rd_data_b != 0) nz++;
        end
        chk("sweep_all_zero", nz, 0);

        // Reset at cycle 4 of a sweep.
        write(6'd9, 4'hF, 32'h99999999);
        write(6'd20, 4'hF, 32'h20202020);
        bus.rd_addr_a = 9;
        #1;
        chk("prefill_9", bus.rd_data_a, 32'h99999999);
        bus.clr = 1;
        tick();
        bus.clr = 0;
        repeat (4) tick();
        chk("busy_before_reset", {31'b0, bus.busy}, 1);
        #2 reset = 1;
        #1;
        chk("async_reset_busy", {31'b0, bus.busy}, 0);
        chk("async_reset_rd9", bus.rd_data_a, 0);
        nz = 0;
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr_a = a[5:0]; bus.rd_addr_b = a[5:0];
            #1;
            if (bus.rd_data_a != 0 || bus.rd_data_b != 0) nz++;
        end
        chk("reset_all_zero", nz, 0);
        tick();
        reset = 0;
        repeat (2) tick();
        chk("no_resume_after_reset", {31'b0, bus.busy}, 0);
        write(6'd1, 4'hF, 32'h00C0FFEE);
        bus.rd_addr_a = 1; bus.rd_addr_b = 9;
        #1;
        chk("post_reset_write1", bus.rd_data_a, 32'h00C0FFEE);
        chk("post_reset_rd9", bus.rd_data_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
